// File: rtl/vc_scheduler.sv
// vc_scheduler: round-robin scheduler moving words from four VC FIFOs to two destination FIFOs.
// Ports: clk, reset, active, vc_empty, vc0..vc3_data, d_almost_full -> vc_pop, d_push, d_data, grant, busy.
module vc_scheduler #(
    parameter int DATA_W = 6,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [3:0]        vc_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic [DATA_W-1:0] vc2_data,
    input  logic [DATA_W-1:0] vc3_data,
    input  logic [1:0]        d_almost_full,
    output logic [3:0]        vc_pop,
    output logic [1:0]        d_push,
    output logic [DATA_W-1:0] d_data,
    output logic [1:0]        grant,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t            state, state_n;
    logic [1:0]        last_grant, last_n, grant_n;
    logic [3:0]        count, count_n;
    logic              pend, pend_n;
    logic [1:0]        pend_vc;
    logic [DATA_W-1:0] pend_data, d_data_n;
    logic [1:0]        d_push_n;
    logic              busy_n;
    logic [1:0]        pick, idx;
    logic              pick_ok;
    logic              pop_ok;

    // Walk offsets 4..1 so the nearest non-empty VC after last_grant wins.
    always_comb begin
        pick    = last_grant;
        pick_ok = 1'b0;
        idx     = last_grant;
        for (int i = 4; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (!vc_empty[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign pop_ok = (state == XFER) && !reset && active
                  && !vc_empty[grant] && (d_almost_full == 2'b00)
                  && (count < BURST_C);

    assign vc_pop = pop_ok ? 4'(4'b0001 << grant) : 4'b0000;

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_grant;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (active && vc_empty != 4'hF)
                    state_n = ARB;
            end
            ARB: begin
                if (active && pick_ok) begin
                    state_n = XFER;
                    grant_n = pick;
                    count_n = 4'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            XFER: begin
                if (!active) begin
                    state_n = IDLE;
                    last_n  = grant;
                end else if (pop_ok) begin
                    count_n = count + 4'd1;
                    if (count_n == BURST_C) begin
                        state_n = ARB;
                        last_n  = grant;
                    end
                end else if (vc_empty[grant]) begin
                    state_n = ARB;
                    last_n  = grant;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        unique case (pend_vc)
            2'd0:    pend_data = vc0_data;
            2'd1:    pend_data = vc1_data;
            2'd2:    pend_data = vc2_data;
            default: pend_data = vc3_data;
        endcase
    end

    // FIFO read data is valid the cycle after the pop, hence the pend stage.
    always_comb begin
        pend_n   = |vc_pop;
        d_push_n = 2'b00;
        d_data_n = d_data;
        if (pend) begin
            d_data_n = pend_data;
            d_push_n = pend_data[DATA_W-1] ? 2'b10 : 2'b01;
        end
        busy_n = (state_n != IDLE) | pend_n | (d_push_n != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            count      <= 4'd0;
            pend       <= 1'b0;
            pend_vc    <= 2'd0;
            d_push     <= 2'b00;
            d_data     <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_n;
            count      <= count_n;
            pend       <= pend_n;
            pend_vc    <= grant;
            d_push     <= d_push_n;
            d_data     <= d_data_n;
            busy       <= busy_n;
        end
    end
endmodule
